// File: rtl/spiker_adapter_pkg.sv
// Shared definitions for the spike adapter blocks (register bank <-> spiker core).
// Holds the reader FSM encoding, the beat-count helper and default stream widths.
package spiker_adapter_pkg;

  localparam int unsigned DEF_CHUNK_WIDTH = 16;
  localparam int unsigned DEF_STEP_WIDTH  = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } reader_state_e;

  // Number of CHUNK-wide beats needed to carry n_bits (ceil division).
  function automatic int unsigned n_beats(input int unsigned n_bits, input int unsigned chunk);
    return (n_bits + chunk - 1) / chunk;
  endfunction

endpackage

// File: rtl/spiker_reader.sv
// spiker_reader: snapshots the input spike register bank on start and streams
// N_SPIKES bits as CHUNK_WIDTH-bit beats over valid/ready, replaying the same
// snapshot for num_steps_i timesteps.
// Ports:
//   clk_i, rst_ni        clock, async active-low reset
//   test_mode_i          no functional effect
//   spikes_i             flattened reg2hw spike words (word i at [(i+1)*WIDTH-1 -: WIDTH])
//   start_i              single-cycle start; num_steps_i latched with it
//   abort_i              synchronous abort of an active transfer
//   spk_data_o/valid_o/ready_i/last_o/step_o  beat stream to the spiker core
//   busy_o               transfer in progress
//   done_o               one-cycle completion pulse
module spiker_reader
  import spiker_adapter_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned N_SPIKES    = 784,
  parameter int unsigned N_REG       = 25,
  parameter int unsigned CHUNK_WIDTH = DEF_CHUNK_WIDTH,
  parameter int unsigned STEP_WIDTH  = DEF_STEP_WIDTH
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   test_mode_i,
  input  logic [N_REG*WIDTH-1:0] spikes_i,
  input  logic                   start_i,
  input  logic [STEP_WIDTH-1:0]  num_steps_i,
  input  logic                   abort_i,
  output logic [CHUNK_WIDTH-1:0] spk_data_o,
  output logic                   spk_valid_o,
  input  logic                   spk_ready_i,
  output logic                   spk_last_o,
  output logic [STEP_WIDTH-1:0]  spk_step_o,
  output logic                   busy_o,
  output logic                   done_o
);

  localparam int unsigned N_BEATS = n_beats(N_SPIKES, CHUNK_WIDTH);
  localparam int unsigned SNAP_W  = N_BEATS * CHUNK_WIDTH;
  localparam int unsigned BEAT_W  = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N_BEATS - 1);

  if (N_REG * WIDTH < N_SPIKES) begin : g_size_check
    $error("spiker_reader: N_REG*WIDTH must cover N_SPIKES");
  end

  reader_state_e          r_state;
  logic [SNAP_W-1:0]      r_snapshot;
  logic [BEAT_W-1:0]      r_beat_cnt;
  logic [STEP_WIDTH-1:0]  r_step_cnt;
  logic [STEP_WIDTH-1:0]  r_steps_q;
  logic [CHUNK_WIDTH-1:0] r_data;
  logic                   r_valid;
  logic                   r_last;
  logic [STEP_WIDTH-1:0]  r_step;
  logic                   r_busy;
  logic                   r_done;

  logic [SNAP_W-1:0]      w_spikes_ext;
  logic [BEAT_W-1:0]      w_next_beat;
  logic [CHUNK_WIDTH-1:0] w_next_data;
  logic [CHUNK_WIDTH-1:0] w_first_data;
  logic                   w_hs;
  logic                   w_last_beat;
  logic                   w_last_step;
  logic                   w_unused_ok;

  // Bits above N_SPIKES are zero so the final beat is padded with zeros.
  assign w_spikes_ext = SNAP_W'(spikes_i[N_SPIKES-1:0]);
  assign w_next_beat  = r_beat_cnt + BEAT_W'(1);
  // Beat-select mux: data for the beat after the current one, and beat 0.
  assign w_next_data  = r_snapshot[int'(w_next_beat) * CHUNK_WIDTH +: CHUNK_WIDTH];
  assign w_first_data = r_snapshot[CHUNK_WIDTH-1:0];
  assign w_hs         = r_valid & spk_ready_i;
  assign w_last_beat  = (r_beat_cnt == LAST_BEAT);
  assign w_last_step  = (r_step_cnt == r_steps_q - STEP_WIDTH'(1));
  assign w_unused_ok  = ^{test_mode_i, spikes_i};

  // Single-process FSM; outputs are registered alongside the state so that
  // the presented beat always matches the counters one cycle ahead.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= S_IDLE;
      r_snapshot <= '0;
      r_beat_cnt <= '0;
      r_step_cnt <= '0;
      r_steps_q  <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
      r_step     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start_i) begin
            r_snapshot <= w_spikes_ext;
            r_steps_q  <= num_steps_i;
            r_beat_cnt <= '0;
            r_step_cnt <= '0;
            r_step     <= '0;
            if (num_steps_i == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_SEND;
              r_valid <= 1'b1;
              r_busy  <= 1'b1;
              r_data  <= w_spikes_ext[CHUNK_WIDTH-1:0];
              r_last  <= (N_BEATS == 1);
            end
          end
        end

        S_SEND: begin
          if (abort_i) begin
            r_state    <= S_IDLE;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_last     <= 1'b0;
            r_data     <= '0;
            r_step     <= '0;
            r_beat_cnt <= '0;
            r_step_cnt <= '0;
          end else if (w_hs) begin
            if (!w_last_beat) begin
              r_beat_cnt <= w_next_beat;
              r_data     <= w_next_data;
              r_last     <= (w_next_beat == LAST_BEAT);
            end else if (w_last_step) begin
              r_beat_cnt <= '0;
              r_step_cnt <= '0;
              r_state    <= S_DONE;
              r_valid    <= 1'b0;
              r_busy     <= 1'b0;
              r_last     <= 1'b0;
              r_data     <= '0;
              r_step     <= '0;
              r_done     <= 1'b1;
            end else begin
              // Next timestep starts immediately, no bubble.
              r_beat_cnt <= '0;
              r_step_cnt <= r_step_cnt + STEP_WIDTH'(1);
              r_step     <= r_step_cnt + STEP_WIDTH'(1);
              r_data     <= w_first_data;
              r_last     <= (N_BEATS == 1);
            end
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_last  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign spk_data_o  = r_data;
  assign spk_valid_o = r_valid;
  assign spk_last_o  = r_last;
  assign spk_step_o  = r_step;
  assign busy_o      = r_busy;
  assign done_o      = r_done;

endmodule
